// File: rtl/axi3_burst_mem_responder.sv
// AXI3 burst slave backed by an internal byte-writable word memory.
// Serves one transaction at a time (FIXED, INCR and WRAP bursts, narrow
// beats and byte strobes) and answers with SLVERR for illegal or
// out-of-range accesses instead of touching memory.
module axi3_burst_mem_responder #(
    parameter int                      data_width_p = 64,
    parameter int                      addr_width_p = 32,
    parameter int                      id_width_p   = 6,
    parameter int                      els_p        = 1024,
    parameter logic [addr_width_p-1:0] base_addr_p  = '0
) (
    input  logic                      aclk,
    input  logic                      aresetn,

    input  logic [addr_width_p-1:0]   s_axi_awaddr,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [id_width_p-1:0]     s_axi_awid,
    input  logic [3:0]                s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,

    input  logic [data_width_p-1:0]   s_axi_wdata,
    input  logic [data_width_p/8-1:0] s_axi_wstrb,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    input  logic [id_width_p-1:0]     s_axi_wid,
    input  logic                      s_axi_wlast,

    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    output logic [id_width_p-1:0]     s_axi_bid,
    output logic [1:0]                s_axi_bresp,

    input  logic [addr_width_p-1:0]   s_axi_araddr,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    input  logic [id_width_p-1:0]     s_axi_arid,
    input  logic [3:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,

    output logic [data_width_p-1:0]   s_axi_rdata,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [id_width_p-1:0]     s_axi_rid,
    output logic                      s_axi_rlast,
    output logic [1:0]                s_axi_rresp
);

    localparam int          strb_w_lp    = data_width_p / 8;
    localparam int          lsb_lp       = $clog2(strb_w_lp);
    localparam int          idx_w_lp     = $clog2(els_p);
    localparam logic [63:0] mem_bytes_lp = 64'(els_p) * 64'(strb_w_lp);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WDATA = 2'd1;
    localparam logic [1:0] ST_WRESP = 2'd2;
    localparam logic [1:0] ST_RDATA = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // True when a byte address falls outside the window backed by memory.
    function automatic logic out_of_range(input logic [addr_width_p-1:0] a);
        logic [63:0] off;
        off = 64'(a) - 64'(base_addr_p);
        return (64'(a) < 64'(base_addr_p)) || (off >= mem_bytes_lp);
    endfunction

    // Word index of a byte address; only meaningful when it is in range.
    function automatic logic [idx_w_lp-1:0] word_idx(input logic [addr_width_p-1:0] a);
        return idx_w_lp'((a - base_addr_p) >> lsb_lp);
    endfunction

    // Address of the following beat for the given burst type.
    function automatic logic [addr_width_p-1:0] next_addr(
        input logic [addr_width_p-1:0] a,
        input logic [2:0]              size,
        input logic [3:0]              len,
        input logic [1:0]              burst
    );
        logic [addr_width_p-1:0] step;
        logic [addr_width_p-1:0] incr;
        logic [addr_width_p-1:0] mask;
        step = addr_width_p'(1) << size;
        incr = (a & ~(step - addr_width_p'(1))) + step;
        mask = ((addr_width_p'(len) + addr_width_p'(1)) << size) - addr_width_p'(1);
        case (burst)
            2'b00:   return a;
            2'b10:   return (a & ~mask) | (incr & mask);
            default: return incr;
        endcase
    endfunction

    // Checks made once on the address phase; a hit poisons the whole burst.
    function automatic logic capture_err(
        input logic [addr_width_p-1:0] a,
        input logic [3:0]              len,
        input logic [2:0]              size,
        input logic [1:0]              burst
    );
        logic [addr_width_p-1:0] step;
        logic                    wrap_len_ok;
        step        = addr_width_p'(1) << size;
        wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
        return (burst == 2'b11) || (size > 3'(lsb_lp)) || out_of_range(a) ||
               ((burst == 2'b10) && (!wrap_len_ok || ((a & (step - addr_width_p'(1))) != '0)));
    endfunction

    logic [data_width_p-1:0] mem [els_p];

    logic [1:0]              state_q, state_d;
    logic                    ready_q, ready_d;
    logic                    prio_wr_q, prio_wr_d;
    logic [addr_width_p-1:0] addr_q, addr_d;
    logic [3:0]              len_q, len_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              burst_q, burst_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    wlast_err_q, wlast_err_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [id_width_p-1:0]   bid_q, bid_d;
    logic                    rvalid_q, rvalid_d;
    logic [data_width_p-1:0] rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic                    rlast_q, rlast_d;
    logic [id_width_p-1:0]   rid_q, rid_d;

    logic [idx_w_lp-1:0]     mem_idx;
    logic [strb_w_lp-1:0]    mem_strb;
    logic                    beat_err;
    logic                    last_beat;
    logic                    start_err;
    logic                    unused_wid;

    // Write interleaving is not supported, so the write ID carries no information.
    assign unused_wid = ^s_axi_wid;

    // Address grants only in IDLE; prio_wr breaks ties so reads and writes alternate.
    assign s_axi_awready = ready_q && (state_q == ST_IDLE) && s_axi_awvalid &&
                           (!s_axi_arvalid || prio_wr_q);
    assign s_axi_arready = ready_q && (state_q == ST_IDLE) && s_axi_arvalid &&
                           (!s_axi_awvalid || !prio_wr_q);
    assign s_axi_wready  = (state_q == ST_WDATA);

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_bid    = bid_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = rresp_q;
    assign s_axi_rlast  = rlast_q;
    assign s_axi_rid    = rid_q;

    // Next-state logic: address capture, per-beat address walk, responses.
    always_comb begin
        state_d     = state_q;
        ready_d     = 1'b1;
        prio_wr_d   = prio_wr_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        wlast_err_d = wlast_err_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        bid_d       = bid_q;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        rlast_d     = rlast_q;
        rid_d       = rid_q;
        mem_idx     = word_idx(addr_q);
        mem_strb    = '0;
        beat_err    = err_q || out_of_range(addr_q);
        last_beat   = (cnt_q == len_q);
        start_err   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s_axi_awready) begin
                    state_d     = ST_WDATA;
                    prio_wr_d   = !prio_wr_q;
                    addr_d      = s_axi_awaddr;
                    len_d       = s_axi_awlen;
                    size_d      = s_axi_awsize;
                    burst_d     = s_axi_awburst;
                    cnt_d       = 4'd0;
                    err_d       = capture_err(s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst);
                    wlast_err_d = 1'b0;
                    bid_d       = s_axi_awid;
                end else if (s_axi_arready) begin
                    start_err = capture_err(s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst);
                    state_d   = ST_RDATA;
                    prio_wr_d = !prio_wr_q;
                    len_d     = s_axi_arlen;
                    size_d    = s_axi_arsize;
                    burst_d   = s_axi_arburst;
                    cnt_d     = 4'd0;
                    err_d     = start_err;
                    addr_d    = next_addr(s_axi_araddr, s_axi_arsize, s_axi_arlen, s_axi_arburst);
                    rid_d     = s_axi_arid;
                    rvalid_d  = 1'b1;
                    rdata_d   = start_err ? '0 : mem[word_idx(s_axi_araddr)];
                    rresp_d   = start_err ? RESP_SLVERR : RESP_OKAY;
                    rlast_d   = (s_axi_arlen == 4'd0);
                end
            end

            ST_WDATA: begin
                if (s_axi_wvalid) begin
                    mem_strb = beat_err ? '0 : s_axi_wstrb;
                    err_d    = beat_err;
                    addr_d   = next_addr(addr_q, size_q, len_q, burst_q);
                    if (s_axi_wlast != last_beat) begin
                        wlast_err_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d  = ST_WRESP;
                        bvalid_d = 1'b1;
                        bresp_d  = (beat_err || wlast_err_d) ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end

            ST_WRESP: begin
                if (s_axi_bready) begin
                    bvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end

            ST_RDATA: begin
                if (s_axi_rready) begin
                    if (last_beat) begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        state_d  = ST_IDLE;
                    end else begin
                        err_d   = beat_err;
                        rdata_d = beat_err ? '0 : mem[mem_idx];
                        rresp_d = beat_err ? RESP_SLVERR : RESP_OKAY;
                        rlast_d = ((cnt_q + 4'd1) == len_q);
                        cnt_d   = cnt_q + 4'd1;
                        addr_d  = next_addr(addr_q, size_q, len_q, burst_q);
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Control and response registers; reset drops any transaction in flight.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            prio_wr_q   <= 1'b1;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            wlast_err_q <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= '0;
            bid_q       <= '0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= '0;
            rlast_q     <= 1'b0;
            rid_q       <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            prio_wr_q   <= prio_wr_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            wlast_err_q <= wlast_err_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            bid_q       <= bid_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            rlast_q     <= rlast_d;
            rid_q       <= rid_d;
        end
    end

    // Byte-lane memory write; contents deliberately survive reset.
    always_ff @(posedge aclk) begin
        for (int b = 0; b < strb_w_lp; b++) begin
            if (mem_strb[b]) begin
                mem[mem_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

endmodule
